processor: RTL and testbench
============================

PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256; instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 256; data memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have no other ports; all state is observed hierarchically.

Function
REQ-006 SHALL be a single-cycle RV32I core: one instruction fetched, executed and retired per rising clk edge.
REQ-007 SHALL support R-type ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, with I-type ALU equivalents (ADDI..SRAI).
REQ-008 SHALL support LW, SW, BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR, LUI and AUIPC; other opcodes SHALL execute as NOP, with PC+4 and no writes.
REQ-009 SHALL fetch combinationally from inst_mem word index pc[31:2]; PC SHALL advance by 4 unless redirected.
REQ-010 SHALL drive br_taken high when the branch condition holds for the current B-type instruction; SHALL drive jump high for JAL/JALR.
REQ-011 SHALL set next PC = PC+imm when br_taken or JAL; = (rs1+imm) & ~1 for JALR; = PC+4 otherwise.
REQ-012 SHALL compute ALU opr_res from opr_a (rs1, or PC for AUIPC/JAL/branch target) and opr_b (rs2 or sign-extended immediate).
REQ-013 SHALL select the write-back value (sel_wb_mux.out_y): ALU result, load data, or PC+4 for JAL/JALR; LUI SHALL write imm[31:12]<<12.
REQ-014 SHALL read the register file combinationally on two ports and write it on the rising edge when the write enable is set and rd != 0.
REQ-015 SHALL read x0 as 0 always; writes to x0 SHALL be discarded.
REQ-016 SHALL read data memory combinationally (LW, word-aligned) and write it on the rising edge (SW); misaligned low address bits SHALL be ignored.
REQ-017 SHALL wrap shift amounts to 5 bits; add/sub SHALL wrap modulo 2^32; the PC SHALL wrap at the instruction memory depth through index truncation.

Reset
REQ-018 SHALL hold PC at 0x00000000 while rst is high, asynchronously.
REQ-019 SHALL NOT reset the register file, instruction memory or data memory, so preloaded contents survive reset.
REQ-020 SHALL fetch the instruction at address 0 on the first rising edge after rst deasserts; deasserting rst mid-cycle SHALL only release PC.

Structure
REQ-021 SHALL hold opcode, funct3 and ALU-op encodings in a shared package used by all sub-modules.
REQ-022 SHALL instantiate inst_mem_i containing array mem[IMEM_WORDS] of 32-bit words.
REQ-023 SHALL instantiate reg_file_i containing array reg_mem[32] of 32-bit words.
REQ-024 SHALL instantiate alu_i with signals opr_a, opr_b and opr_res.
REQ-025 SHALL instantiate sel_wb_mux with output out_y.
REQ-026 SHALL expose top-level nets br_taken and jump.
REQ-027 SHALL be preloadable by $readmemh on inst_mem_i.mem and by $readmemb on reg_file_i.reg_mem at time 0.
REQ-028 SHALL contain the ALU as its natural sub-module (alu); the controller and immediate generator SHALL remain combinational blocks in the top level.

Verification
REQ-029 SHALL pass: preload x1=5, x2=7; program add x3,x1,x2 at PC 0 -> after one edge, x3=0x0000000C.
REQ-030 SHALL pass: dmem[1]=0xDEADBEEF; lw x4,4(x0) -> x4=0xDEADBEEF; follow with sw x4,8(x0) -> dmem[2]=0xDEADBEEF.
REQ-031 SHALL pass: jal x5,+8 at PC 0x0C -> x5=0x00000010, jump=1, next PC=0x14.
REQ-032 SHALL pass: lui x6,0x12345 -> x6=0x12345000; auipc x7,0x1 at PC 0x14 -> x7=0x00001014.
REQ-033 SHALL pass: beq x1,x1,+8 at PC 0x20 -> br_taken=1, next PC=0x28; bne x1,x1,+8 -> br_taken=0, next PC=PC+4.
REQ-034 SHALL pass: addi x0,x0,5 -> x0 stays 0; rst asserted mid-program -> PC=0 immediately, registers unchanged.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared encodings for the single-cycle RV32I core.
// Opcodes, funct3 values, ALU ops and datapath select codes.
package processor_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;

    // bit 30 selects SUB only for R-type; it selects SRA for both forms
    function automatic alu_op_e alu_dec(
        input logic [2:0] f3,
        input logic       alt,
        input logic       is_r
    );
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'b000: if (is_r && alt) op = ALU_SUB;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: if (alt) op = ALU_SRA; else op = ALU_SRL;
            3'b110: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/processor_if.sv
// Operand/result bundle between the core datapath and its ALU.
// The datapath is master, the ALU is slave.
interface processor_if;
    import processor_pkg::*;

    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic [31:0] opr_res;
    alu_op_e     alu_op;

    modport master (output opr_a, opr_b, alu_op, input opr_res);
    modport slave  (input opr_a, opr_b, alu_op, output opr_res);

endinterface

// File: rtl/processor_alu.sv
// RV32I integer ALU; shifts use the low five bits of opr_b.
module alu (
    processor_if.slave bus
);
    import processor_pkg::*;

    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic [31:0] opr_res;
    logic [4:0]  shamt;

    assign opr_a = bus.opr_a;
    assign opr_b = bus.opr_b;
    assign shamt = opr_b[4:0];

    always_comb begin
        opr_res = '0;
        case (bus.alu_op)
            ALU_ADD:  opr_res = opr_a + opr_b;
            ALU_SUB:  opr_res = opr_a - opr_b;
            ALU_SLL:  opr_res = opr_a << shamt;
            ALU_SLT:  opr_res = {31'd0, $signed(opr_a) < $signed(opr_b)};
            ALU_SLTU: opr_res = {31'd0, opr_a < opr_b};
            ALU_XOR:  opr_res = opr_a ^ opr_b;
            ALU_SRL:  opr_res = opr_a >> shamt;
            ALU_SRA:  opr_res = $unsigned($signed(opr_a) >>> shamt);
            ALU_OR:   opr_res = opr_a | opr_b;
            ALU_AND:  opr_res = opr_a & opr_b;
            default:  opr_res = '0;
        endcase
    end

    assign bus.opr_res = opr_res;

endmodule

// File: rtl/processor_inst_mem.sv
// Instruction memory: combinational word read, synchronous program port.
// Index truncation makes the fetch address wrap at the memory depth.
module inst_mem #(
    parameter int WORDS = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(WORDS)-1:0] addr,
    output logic [31:0]              inst
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign inst = mem[addr];

endmodule

// File: rtl/processor_reg_file.sv
// 32x32 register file, two combinational read ports, one write port.
// x0 reads as zero and is never written; contents are not reset.
module reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] reg_mem [32];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) reg_mem[wa] <= wd;
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : reg_mem[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : reg_mem[ra2];

endmodule

// File: rtl/processor_wb_mux.sv
// Register write-back source select.
module wb_mux
    import processor_pkg::*;
(
    input  wb_sel_e     sel,
    input  logic [31:0] alu_res,
    input  logic [31:0] mem_data,
    input  logic [31:0] pc_plus4,
    output logic [31:0] out_y
);

    always_comb begin
        out_y = alu_res;
        case (sel)
            WB_MEM:  out_y = mem_data;
            WB_PC4:  out_y = pc_plus4;
            default: out_y = alu_res;
        endcase
    end

endmodule

// File: rtl/processor.sv
// Single-cycle RV32I core: fetch, decode, execute and retire per clk edge.
// Decoder and immediate generation live here; memories are not reset.
module processor #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic clk,
    input logic rst
);
    import processor_pkg::*;

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc_q, pc_d, pc_plus4, inst;
    logic [31:0] rs1_data, rs2_data, imm, wb_data, dm_rdata;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        br_taken, jump, jalr, rf_we, dm_we, b_imm;
    logic [DAW-1:0] dm_idx;
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    a_sel_e      a_sel;
    logic [31:0] dmem [DMEM_WORDS];

    processor_if alu_bus ();

    inst_mem #(.WORDS(IMEM_WORDS)) inst_mem_i (
        .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
        .addr(pc_q[IAW+1:2]), .inst(inst)
    );

    // no architectural writes while rst is high
    reg_file reg_file_i (
        .clk(clk), .we(rf_we && !rst),
        .ra1(inst[19:15]), .ra2(inst[24:20]), .wa(inst[11:7]),
        .wd(wb_data), .rd1(rs1_data), .rd2(rs2_data)
    );

    alu alu_i (.bus(alu_bus));

    wb_mux sel_wb_mux (
        .sel(wb_sel), .alu_res(alu_bus.opr_res), .mem_data(dm_rdata),
        .pc_plus4(pc_plus4), .out_y(wb_data)
    );

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign pc_plus4 = pc_q + 32'd4;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    always_comb begin
        imm      = '0;
        alu_op   = ALU_ADD;
        a_sel    = A_RS1;
        b_imm    = 1'b0;
        wb_sel   = WB_ALU;
        rf_we    = 1'b0;
        dm_we    = 1'b0;
        br_taken = 1'b0;
        jump     = 1'b0;
        jalr     = 1'b0;
        case (opcode)
            OP_R: begin
                alu_op = alu_dec(funct3, inst[30], 1'b1);
                rf_we  = 1'b1;
            end
            OP_I: begin
                imm    = imm_i;
                b_imm  = 1'b1;
                alu_op = alu_dec(funct3, inst[30], 1'b0);
                rf_we  = 1'b1;
            end
            OP_LOAD: if (funct3 == F3_W) begin
                imm    = imm_i;
                b_imm  = 1'b1;
                wb_sel = WB_MEM;
                rf_we  = 1'b1;
            end
            OP_STORE: if (funct3 == F3_W) begin
                imm   = imm_s;
                b_imm = 1'b1;
                dm_we = 1'b1;
            end
            OP_BRANCH: begin
                imm   = imm_b;
                b_imm = 1'b1;
                a_sel = A_PC;
                case (funct3)
                    F3_BEQ:  br_taken = rs1_data == rs2_data;
                    F3_BNE:  br_taken = rs1_data != rs2_data;
                    F3_BLT:  br_taken = $signed(rs1_data) < $signed(rs2_data);
                    F3_BGE:  br_taken = $signed(rs1_data) >= $signed(rs2_data);
                    F3_BLTU: br_taken = rs1_data < rs2_data;
                    F3_BGEU: br_taken = rs1_data >= rs2_data;
                    default: br_taken = 1'b0;
                endcase
            end
            OP_JAL: begin
                imm    = imm_j;
                b_imm  = 1'b1;
                a_sel  = A_PC;
                wb_sel = WB_PC4;
                rf_we  = 1'b1;
                jump   = 1'b1;
            end
            OP_JALR: if (funct3 == F3_JALR) begin
                imm    = imm_i;
                b_imm  = 1'b1;
                wb_sel = WB_PC4;
                rf_we  = 1'b1;
                jump   = 1'b1;
                jalr   = 1'b1;
            end
            OP_LUI: begin
                imm   = imm_u;
                b_imm = 1'b1;
                a_sel = A_ZERO;
                rf_we = 1'b1;
            end
            OP_AUIPC: begin
                imm   = imm_u;
                b_imm = 1'b1;
                a_sel = A_PC;
                rf_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_bus.opr_a  = (a_sel == A_PC)   ? pc_q :
                            (a_sel == A_ZERO) ? 32'd0 : rs1_data;
    assign alu_bus.opr_b  = b_imm ? imm : rs2_data;
    assign alu_bus.alu_op = alu_op;

    assign dm_idx   = alu_bus.opr_res[DAW+1:2];
    assign dm_rdata = dmem[dm_idx];

    always_ff @(posedge clk) begin
        if (dm_we && !rst) dmem[dm_idx] <= rs2_data;
    end

    // the ALU already holds every redirect target; JALR clears bit 0
    always_comb begin
        pc_d = pc_plus4;
        if (br_taken || jump) begin
            pc_d = {alu_bus.opr_res[31:1], alu_bus.opr_res[0] & ~jalr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= '0;
        else     pc_q <= pc_d;
    end

endmodule

// File: tb/tb_processor.sv
// Directed-program bench for the single-cycle core with an ISA-level model.
module tb_processor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    logic [31:0] m_imem [256];
    logic [31:0] m_dm   [256];
    logic [31:0] m_x    [32];
    logic [31:0] m_pc   = 32'd0;
    logic [31:0] prog   [28];

    processor #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1,
                                          int f3, int rd);
        logic [31:0] a, b, c, d, e;
        a = f7; b = rs2; c = rs1; d = f3; e = rd;
        return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3,
                                          int rd, int op);
        logic [31:0] a, c, d, e, o;
        a = imm; c = rs1; d = f3; e = rd; o = op;
        return {a[11:0], c[4:0], d[2:0], e[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [31:0] a, b, c;
        a = imm; b = rs2; c = rs1;
        return {a[11:5], b[4:0], c[4:0], 3'd2, a[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] a, b, c, d;
        a = imm; b = rs2; c = rs1; d = f3;
        return {a[12], a[10:5], b[4:0], c[4:0], d[2:0],
                a[4:1], a[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int imm, int rd, int op);
        logic [31:0] a, e, o;
        a = imm; e = rd; o = op;
        return {a[19:0], e[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] a, e;
        a = imm; e = rd;
        return {a[20], a[10:1], a[11], a[19:12], e[4:0], 7'h6F};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(logic [2:0] f3, logic alt,
                                            logic [31:0] x, logic [31:0] y);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // executes the instruction at m_pc; commit=0 only reports br/jump
    task automatic model_exec(input bit commit, output bit br, output bit jmp);
        logic [31:0] in, a, b, ii, is, ib, iu, ij, res, npc, ea;
        logic [2:0] f3;
        bit wr;
        in  = m_imem[m_pc[9:2]];
        f3  = in[14:12];
        a   = m_x[in[19:15]];
        b   = m_x[in[24:20]];
        ii  = {{20{in[31]}}, in[31:20]};
        is  = {{20{in[31]}}, in[31:25], in[11:7]};
        ib  = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
        iu  = {in[31:12], 12'd0};
        ij  = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
        br  = 1'b0;
        jmp = 1'b0;
        wr  = 1'b0;
        res = '0;
        npc = m_pc + 32'd4;
        case (in[6:0])
            7'h33: begin wr = 1; res = ref_alu(f3, in[30], a, b); end
            7'h13: begin
                wr = 1; res = ref_alu(f3, in[30] && f3 == 3'd5, a, ii);
            end
            7'h03: if (f3 == 3'd2) begin
                wr = 1; ea = a + ii; res = m_dm[ea[9:2]];
            end
            7'h23: if (f3 == 3'd2 && commit) begin
                ea = a + is; m_dm[ea[9:2]] = b;
            end
            7'h63: begin
                case (f3)
                    3'd0: br = (a == b);
                    3'd1: br = (a != b);
                    3'd4: br = ($signed(a) < $signed(b));
                    3'd5: br = ($signed(a) >= $signed(b));
                    3'd6: br = (a < b);
                    3'd7: br = (a >= b);
                    default: br = 1'b0;
                endcase
                if (br) npc = m_pc + ib;
            end
            7'h6F: begin jmp = 1; wr = 1; res = m_pc + 4; npc = m_pc + ij; end
            7'h67: if (f3 == 3'd0) begin
                jmp = 1; wr = 1; res = m_pc + 4;
                ea = a + ii; npc = {ea[31:1], 1'b0};
            end
            7'h37: begin wr = 1; res = iu; end
            7'h17: begin wr = 1; res = m_pc + iu; end
            default: ;
        endcase
        if (commit) begin
            if (wr && in[11:7] != 5'd0) m_x[in[11:7]] = res;
            m_pc = npc;
        end
    endtask

    always @(posedge rst) m_pc = 32'd0;

    always @(posedge clk) begin
        bit b0, j0;
        if (armed && !rst) model_exec(1'b1, b0, j0);
    end

    always @(negedge clk) begin
        bit eb, ej;
        if (armed) begin
            model_exec(1'b0, eb, ej);
            chk("pc", dut.pc_q, m_pc);
            chk("br_taken", {31'd0, dut.br_taken}, {31'd0, eb});
            chk("jump", {31'd0, dut.jump}, {31'd0, ej});
            for (int i = 0; i < 32; i++)
                chk($sformatf("x%0d", i), dut.reg_file_i.reg_mem[i], m_x[i]);
            for (int i = 0; i < 4; i++)
                chk($sformatf("dmem%0d", i), dut.dmem[i], m_dm[i]);
        end
    end

    task automatic run_to(input logic [31:0] target, input string nm);
        int n;
        n = 0;
        while (dut.pc_q !== target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (dut.pc_q !== target) chk(nm, dut.pc_q, target);
    endtask

    initial begin
        prog[0]  = enc_r(0, 2, 1, 0, 3);
        prog[1]  = enc_i(4, 0, 2, 4, 7'h03);
        prog[2]  = enc_s(8, 4, 0);
        prog[3]  = enc_j(8, 5);
        prog[4]  = enc_i(1, 0, 0, 9, 7'h13);
        prog[5]  = enc_u(1, 7, 7'h17);
        prog[6]  = enc_u(32'h12345, 6, 7'h37);
        prog[7]  = enc_i(5, 0, 0, 0, 7'h13);
        prog[8]  = enc_b(8, 1, 1, 0);
        prog[9]  = enc_i(2, 0, 0, 9, 7'h13);
        prog[10] = enc_b(8, 1, 1, 1);
        prog[11] = enc_r(32, 2, 1, 0, 8);
        prog[12] = enc_r(32, 1, 8, 5, 10);
        prog[13] = enc_r(0, 1, 8, 5, 11);
        prog[14] = enc_r(0, 1, 8, 2, 12);
        prog[15] = enc_r(0, 1, 8, 3, 13);
        prog[16] = enc_i(31, 1, 1, 14, 7'h13);
        prog[17] = enc_b(8, 1, 8, 4);
        prog[18] = enc_i(3, 0, 0, 9, 7'h13);
        prog[19] = enc_b(8, 1, 8, 7);
        prog[20] = enc_i(4, 0, 0, 9, 7'h13);
        prog[21] = enc_i(32'h5C, 1, 0, 15, 7'h67);
        prog[22] = enc_i(5, 0, 0, 9, 7'h13);
        prog[23] = enc_i(6, 0, 0, 9, 7'h13);
        prog[24] = enc_i(32'hFFF, 2, 4, 16, 7'h13);
        prog[25] = enc_i(32'h30, 1, 6, 17, 7'h13);
        prog[26] = 32'h0000000B;
        prog[27] = enc_j(0, 0);

        for (int i = 0; i < 256; i++) begin
            m_imem[i] = (i < 28) ? prog[i] : 32'd0;
            m_dm[i]   = (i == 1) ? 32'hDEADBEEF : 32'd0;
            dut.inst_mem_i.mem[i] <= m_imem[i];
            dut.dmem[i] <= m_dm[i];
        end
        for (int i = 0; i < 32; i++) begin
            m_x[i] = (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : 32'd0;
            dut.reg_file_i.reg_mem[i] <= m_x[i];
        end
        #1 armed = 1'b1;

        @(negedge clk);
        chk("reset_pc", dut.pc_q, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;

        run_to(32'h0C, "reach_jal");
        chk("jal_jump", {31'd0, dut.jump}, 32'd1);
        @(negedge clk);
        chk("jal_next_pc", dut.pc_q, 32'h14);
        chk("jal_link_x5", dut.reg_file_i.reg_mem[5], 32'h10);

        run_to(32'h20, "reach_beq");
        chk("beq_taken", {31'd0, dut.br_taken}, 32'd1);
        @(negedge clk);
        chk("beq_next_pc", dut.pc_q, 32'h28);
        chk("bne_not_taken", {31'd0, dut.br_taken}, 32'd0);
        @(negedge clk);
        chk("bne_next_pc", dut.pc_q, 32'h2C);

        run_to(32'h6C, "reach_loop");
        chk("add_x3", dut.reg_file_i.reg_mem[3], 32'h0000000C);
        chk("lw_x4", dut.reg_file_i.reg_mem[4], 32'hDEADBEEF);
        chk("sw_dmem2", dut.dmem[2], 32'hDEADBEEF);
        chk("lui_x6", dut.reg_file_i.reg_mem[6], 32'h12345000);
        chk("auipc_x7", dut.reg_file_i.reg_mem[7], 32'h00001014);
        chk("x0_zero", dut.reg_file_i.reg_mem[0], 32'h0);
        chk("skipped_x9", dut.reg_file_i.reg_mem[9], 32'h0);
        chk("sub_x8", dut.reg_file_i.reg_mem[8], 32'hFFFFFFFE);
        chk("sra_x10", dut.reg_file_i.reg_mem[10], 32'hFFFFFFFF);
        chk("srl_x11", dut.reg_file_i.reg_mem[11], 32'h07FFFFFF);
        chk("slt_x12", dut.reg_file_i.reg_mem[12], 32'h1);
        chk("sltu_x13", dut.reg_file_i.reg_mem[13], 32'h0);
        chk("slli_x14", dut.reg_file_i.reg_mem[14], 32'h80000000);
        chk("jalr_x15", dut.reg_file_i.reg_mem[15], 32'h58);
        chk("xori_x16", dut.reg_file_i.reg_mem[16], 32'hFFFFFFF8);
        chk("ori_x17", dut.reg_file_i.reg_mem[17], 32'h35);
        chk("loop_jump", {31'd0, dut.jump}, 32'd1);

        @(negedge clk);
        #2;
        dut.reg_file_i.reg_mem[3] <= 32'h55;
        m_x[3] = 32'h55;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_pc_async", dut.pc_q, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_keeps_x3", dut.reg_file_i.reg_mem[3], 32'h55);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("first_fetch_after_rst", dut.pc_q, 32'h4);
        run_to(32'h6C, "reach_loop_again");
        chk("rerun_x3", dut.reg_file_i.reg_mem[3], 32'h0000000C);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
